// File: rtl/tl_ul_sram_responder_if.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder_if
// Purpose : 32-bit TileLink-UL A/D channel bundle between an initiator and
//           the tl_ul_sram_responder scratchpad.
// Signals : A channel  a_valid/a_ready handshake, a_opcode, a_param, a_size,
//                      a_source, a_address, a_mask, a_data, a_corrupt
//           D channel  d_valid/d_ready handshake, d_opcode, d_param, d_size,
//                      d_source, d_sink, d_denied, d_data, d_corrupt
// Modports: master - initiator side (drives A payload and d_ready)
//           slave  - responder side (drives a_ready and D payload)
// ---------------------------------------------------------------------------
interface tl_ul_sram_responder_if #(
    parameter int SOURCE_W = 3
) ();

    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                a_corrupt;

    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic                d_denied;
    logic [31:0]         d_data;
    logic                d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source,
               a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source,
               a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );

endinterface

// File: rtl/tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder
// Purpose : TileLink-UL manager endpoint backed by a DEPTH x 32-bit register
//           array. Serves Get / PutFullData / PutPartialData and returns
//           AccessAck / AccessAckData / HintAck through a 2-entry response
//           queue so a stalled d_ready never loses a beat.
// Ports   : clock  - sole clock, all state on posedge
//           reset  - synchronous, active-high; clears the response queue
//                    (memory contents are kept)
//           tl     - tl_ul_sram_responder_if.slave (A in, D out)
// Params  : DEPTH    number of 32-bit words (power of 2, >= 2)
//           SOURCE_W width of a_source / d_source (must match the interface)
// Config  : TL_RANGE_ERR_EN - when defined, word addresses >= DEPTH are
//           refused (no write, d_denied=1, Get also d_corrupt=1 / data 0).
//           When undefined the word index simply wraps onto the array.
// ---------------------------------------------------------------------------
module tl_ul_sram_responder #(
    parameter int DEPTH    = 256,
    parameter int SOURCE_W = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    tl_ul_sram_responder_if.slave   tl
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGICAL     = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          size;
        logic [SOURCE_W-1:0] source;
        logic                denied;
        logic                corrupt;
        logic [31:0]         data;
    } rsp_t;

    logic [31:0]   mem [DEPTH];

    rsp_t          q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic          a_fire;
    logic          d_fire;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          do_write;
    rsp_t          rsp_next;
    rsp_t          head;

    // a_ready depends only on registered occupancy (and reset), never on
    // d_ready, so there is no combinational path through the block.
    assign tl.a_ready = (count != 2'd2) & ~reset;
    assign tl.d_valid = (count != 2'd0);

    assign a_fire = tl.a_valid & tl.a_ready;
    assign d_fire = tl.d_valid & tl.d_ready;

    assign idx = tl.a_address[AW+1:2];

`ifdef TL_RANGE_ERR_EN
    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH);
    assign out_of_range = (tl.a_address[31:2] >= WORD_LIMIT);
`else
    assign out_of_range = 1'b0;
`endif

    // a_param, the byte offset and upper address bits carry no meaning here.
    logic unused_a_bits;
    assign unused_a_bits = ^{tl.a_param, tl.a_address[1:0], tl.a_address[31:AW+2]};

    // Response formed from the A beat; Get data is the array value before
    // any write on the same edge (only one request is accepted per cycle).
    always_comb begin
        rsp_next         = '0;
        rsp_next.size    = tl.a_size;
        rsp_next.source  = tl.a_source;
        do_write         = 1'b0;
        case (tl.a_opcode)
            OP_PUT_FULL, OP_PUT_PARTIAL: begin
                rsp_next.opcode = D_ACCESS_ACK;
                rsp_next.denied = out_of_range;
                // Poisoned write data is dropped silently.
                do_write        = ~tl.a_corrupt & ~out_of_range;
            end
            OP_GET: begin
                rsp_next.opcode = D_ACCESS_ACK_DATA;
                if (out_of_range) begin
                    rsp_next.denied  = 1'b1;
                    rsp_next.corrupt = 1'b1;
                end else begin
                    rsp_next.data    = mem[idx];
                end
            end
            OP_ARITH, OP_LOGICAL: begin
                rsp_next.opcode  = D_ACCESS_ACK_DATA;
                rsp_next.denied  = 1'b1;
                rsp_next.corrupt = 1'b1;
            end
            OP_HINT: begin
                rsp_next.opcode = D_HINT_ACK;
                rsp_next.denied = out_of_range;
            end
            default: begin
                rsp_next.opcode = D_ACCESS_ACK;
                rsp_next.denied = 1'b1;
            end
        endcase
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (a_fire && do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (tl.a_mask[b]) begin
                    mem[idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            q[0]   <= '0;
            q[1]   <= '0;
        end else begin
            if (a_fire) begin
                q[wr_ptr] <= rsp_next;
                wr_ptr    <= ~wr_ptr;
            end
            if (d_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({a_fire, d_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = q[rd_ptr];

    assign tl.d_opcode  = head.opcode;
    assign tl.d_param   = 2'b00;
    assign tl.d_size    = head.size;
    assign tl.d_source  = head.source;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = head.denied;
    assign tl.d_data    = head.data;
    assign tl.d_corrupt = head.corrupt;

endmodule
